hosted_npu_irq_ctrl: RTL and testbench
======================================

# hosted_npu_irq_ctrl

Parametrised interrupt and reset controller for a hosted system with `N_CH` NPU instances behind one host core. It collects per-NPU interrupt lines into a single registered `irq_core`, with per-channel enable, level/edge mode, W1C pending and a claim register. It also sequences per-NPU soft-reset pulses under software control. It sits between the NPU array and the host core; the interconnect drives it through a simple register port.

## Interface
- `N_CH`, 4: number of NPU channels, 1..32
- `RST_CYCLES`, 16: length of each NPU reset pulse in cycles, ≥1
- `ADDR_W`, 3: register word-address width
- `clk` in 1: system clock
- `srst` in 1: reset, synchronous, active-high
- `irq_in` in N_CH: NPU interrupt lines, synchronous to `clk`
- `npu_rst_n` out N_CH: per-NPU reset, active-low
- `irq_core` out 1: aggregated interrupt to host core
- `reg_valid` in 1: register request
- `reg_write` in 1: 1 = write, 0 = read
- `reg_addr` in ADDR_W: word address
- `reg_wdata` in 32: write data
- `reg_ready` out 1: request accepted, always 1
- `reg_rvalid` out 1: read data valid
- `reg_rdata` out 32: read data

## Operation
- Register map (word addr); bits above N_CH read 0 and ignore writes:
  - 0 PENDING: RO; write-1-to-clear for edge channels only
  - 1 ENABLE: RW
  - 2 MODE: RW; 0 = level, 1 = edge
  - 3 RST_CTRL: write bit i = 1 starts the reset pulse on channel i; read returns per-channel busy
  - 4 CLAIM: RO; `{valid[31], id[4:0]}` = lowest-index channel with pending & enable. Reading CLAIM clears that channel's pending bit if it is an edge channel.
  - 5..7: read 0; writes ignored
- Level channel: `pending[i]` <= `irq_in[i]` each cycle; W1C and claim have no effect.
- Edge channel: `pending[i]` is set when `irq_in[i]` is 1 and was 0 in the previous cycle. It clears on W1C or claim. If set and clear occur in the same cycle, set wins.
- Changing MODE does not alter `pending`; the new rule applies from the next cycle.
- Reset pulse: channel i drives `npu_rst_n[i]` = 0 for exactly RST_CYCLES cycles, then 1. A start request while channel i is busy is ignored; the pulse is not extended.
- While channel i is busy:
  - `pending[i]` is forced to 0.
  - Its edge history register is forced to 1, so no edge is detected on release from an already-high line.
- `irq_core` = |(pending & enable), registered.

## Timing
- srst values:
  - pending, enable, mode = 0
  - `irq_core` = 0
  - `reg_rvalid` = 0, `reg_rdata` = 0
  - all channels busy; `npu_rst_n` = 0
- After srst deasserts, `npu_rst_n` stays 0 for RST_CYCLES further cycles, then goes to 1 on all channels together.
- srst asserted mid-pulse restarts all counters.
- Reads: request accepted in cycle T; `reg_rvalid` = 1 with data in T+1 only. Back-to-back reads are allowed.
- Writes take effect at the end of the accept cycle; a read in T+1 sees the new value.
- RST_CTRL write accepted in T: `npu_rst_n[i]` = 0 from T+1 through T+RST_CYCLES, and 1 at T+RST_CYCLES+1.
- `irq_in` rising in T (edge mode, enabled): `pending` is 1 in T+1 and `irq_core` is 1 in T+2.
- Claim read in T returns the state as of T. The pending clear is visible in T+1, and `irq_core` updates in T+2.
- Reset counter width: $clog2(RST_CYCLES+1); the counter saturates at 0 when idle.

## Structure
- Package `hosted_npu_irq_ctrl_pkg`:
  - register address constants (`IRQ_PENDING`…`IRQ_CLAIM`)
  - `irq_mode_e` {IRQ_LEVEL, IRQ_EDGE}
  - claim word field positions
- Sub-module `hosted_npu_rst_pulse`, one per channel: down-counter with `start`, `srst` and `busy`; drives `npu_rst_n`.
- Lowest-index priority encoder for CLAIM is a function in the package.

## Test plan
- Reset release, RST_CYCLES = 16: `npu_rst_n` = 0 for 16 cycles after srst deassert, then 0xF; every register reads 0.
- Edge mode, ENABLE = 0x5, pulse `irq_in[2]` for 1 cycle: PENDING = 0x4 and `irq_core` rises 2 cycles after the edge. W1C 0x4 drops `irq_core` 2 cycles later.
- Level mode, ch1 enabled, `irq_in[1]` held high: a W1C of 0x2 leaves PENDING = 0x2. Dropping the line clears PENDING next cycle.
- Channels 1 and 3 pending (edge): CLAIM reads 0x80000001 then 0x80000003, then 0x00000000.
- Write RST_CTRL = 0x2, rewrite it 5 cycles later: one 16-cycle pulse on ch1 only. RST_CTRL reads 0x2 during the pulse; an `irq_in[1]` edge during the pulse is not latched.
- Edge set coinciding with W1C on the same channel: PENDING bit remains 1.

Source files
------------

// File: rtl/hosted_npu_irq_ctrl_pkg.sv
// hosted_npu_irq_ctrl_pkg
// Shared definitions for the hosted NPU interrupt/reset controller:
//   - register word addresses
//   - per-channel interrupt mode encoding
//   - CLAIM word layout and the lowest-index priority encoder behind it
package hosted_npu_irq_ctrl_pkg;

  localparam int unsigned IRQ_PENDING  = 0;
  localparam int unsigned IRQ_ENABLE   = 1;
  localparam int unsigned IRQ_MODE     = 2;
  localparam int unsigned IRQ_RST_CTRL = 3;
  localparam int unsigned IRQ_CLAIM    = 4;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  localparam int unsigned CLAIM_VALID_BIT = 31;
  localparam int unsigned CLAIM_ID_LSB    = 0;
  localparam int unsigned CLAIM_ID_W      = 5;

  typedef struct packed {
    logic                  valid;
    logic [CLAIM_ID_W-1:0] id;
  } claim_t;

  // Scans from the top down so the last hit written is the lowest index.
  function automatic claim_t find_lowest(input logic [31:0] vec);
    claim_t c;
    c.valid = 1'b0;
    c.id    = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        c.valid = 1'b1;
        c.id    = CLAIM_ID_W'(i);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] claim_word(input claim_t c);
    logic [31:0] w;
    w = '0;
    w[CLAIM_VALID_BIT]                 = c.valid;
    w[CLAIM_ID_LSB +: CLAIM_ID_W]      = c.id;
    return w;
  endfunction

endpackage

// File: rtl/hosted_npu_irq_ctrl_rst_pulse.sv
// hosted_npu_rst_pulse
// One NPU soft-reset sequencer: a down-counter loaded with RST_CYCLES on
// srst or on an accepted start, held at 0 when idle.
//   clk       in  system clock
//   srst      in  synchronous active-high reset (restarts the pulse)
//   start     in  request a new pulse; ignored while busy
//   busy      out pulse in progress
//   npu_rst_n out active-low reset to the NPU, low exactly while busy
module hosted_npu_rst_pulse #(
  parameter int RST_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic start,
  output logic busy,
  output logic npu_rst_n
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // A start while the counter is non-zero is dropped, so a pulse is never extended.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= CNT_W'(RST_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (start) begin
      cnt_q <= CNT_W'(RST_CYCLES);
    end
  end

  assign busy      = (cnt_q != '0);
  assign npu_rst_n = ~busy;

endmodule

// File: rtl/hosted_npu_irq_ctrl.sv
// hosted_npu_irq_ctrl
// Collects N_CH NPU interrupt lines into one registered host interrupt and
// sequences per-NPU soft-reset pulses, all driven through a small register port.
//   clk, srst           clock, synchronous active-high reset
//   irq_in[N_CH]        NPU interrupt lines (synchronous to clk)
//   npu_rst_n[N_CH]     per-NPU active-low reset
//   irq_core            |(pending & enable), registered
//   reg_valid/write/addr/wdata   register request (always accepted)
//   reg_ready           constant 1
//   reg_rvalid/rdata    read response, one cycle after the request
module hosted_npu_irq_ctrl
  import hosted_npu_irq_ctrl_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int RST_CYCLES = 16,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [N_CH-1:0]   irq_in,
  output logic [N_CH-1:0]   npu_rst_n,
  output logic              irq_core,
  input  logic              reg_valid,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic              reg_ready,
  output logic              reg_rvalid,
  output logic [31:0]       reg_rdata
);

  logic [N_CH-1:0] pending_q, enable_q, mode_q, hist_q;
  logic [N_CH-1:0] busy, rst_start, force_clr, w1c, claim_clr;
  logic [N_CH-1:0] pending_d, hist_d;
  logic            wr_en, rd_en;
  logic            sel_pending, sel_enable, sel_mode, sel_rst, sel_claim;
  claim_t          claim;
  logic [31:0]     rd_data;
  logic            unused_wdata;

  assign wr_en       = reg_valid & reg_write;
  assign rd_en       = reg_valid & ~reg_write;
  assign sel_pending = (reg_addr == ADDR_W'(IRQ_PENDING));
  assign sel_enable  = (reg_addr == ADDR_W'(IRQ_ENABLE));
  assign sel_mode    = (reg_addr == ADDR_W'(IRQ_MODE));
  assign sel_rst     = (reg_addr == ADDR_W'(IRQ_RST_CTRL));
  assign sel_claim   = (reg_addr == ADDR_W'(IRQ_CLAIM));

  assign reg_ready    = 1'b1;
  assign unused_wdata = ^reg_wdata;

  assign claim     = find_lowest(32'(pending_q & enable_q));
  assign w1c       = (wr_en && sel_pending) ? reg_wdata[N_CH-1:0] : '0;
  assign rst_start = (wr_en && sel_rst) ? reg_wdata[N_CH-1:0] : '0;
  // Including the start cycle keeps pending at 0 for every cycle npu_rst_n is low.
  assign force_clr = busy | rst_start;

  for (genvar g = 0; g < N_CH; g++) begin : g_rst
    hosted_npu_rst_pulse #(
      .RST_CYCLES(RST_CYCLES)
    ) u_rst_pulse (
      .clk      (clk),
      .srst     (srst),
      .start    (rst_start[g]),
      .busy     (busy[g]),
      .npu_rst_n(npu_rst_n[g])
    );
  end

  always_comb begin
    claim_clr = '0;
    if (rd_en && sel_claim && claim.valid) begin
      claim_clr = N_CH'(1) << claim.id;
    end
  end

  // Edge history is held at 1 during a reset pulse so an already-high line
  // does not register as a fresh edge on release. In edge mode a new edge
  // beats a simultaneous W1C/claim clear.
  always_comb begin
    pending_d = '0;
    hist_d    = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (!force_clr[i]) begin
        hist_d[i] = irq_in[i];
        if (irq_mode_e'(mode_q[i]) == IRQ_EDGE) begin
          pending_d[i] = (irq_in[i] & ~hist_q[i]) |
                         (pending_q[i] & ~(w1c[i] | claim_clr[i]));
        end else begin
          pending_d[i] = irq_in[i];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_pending)      rd_data = 32'(pending_q);
    else if (sel_enable)  rd_data = 32'(enable_q);
    else if (sel_mode)    rd_data = 32'(mode_q);
    else if (sel_rst)     rd_data = 32'(busy);
    else if (sel_claim)   rd_data = claim_word(claim);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      hist_q     <= '1;
      irq_core   <= 1'b0;
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      pending_q <= pending_d;
      hist_q    <= hist_d;
      if (wr_en && sel_enable) enable_q <= reg_wdata[N_CH-1:0];
      if (wr_en && sel_mode)   mode_q   <= reg_wdata[N_CH-1:0];
      irq_core   <= |(pending_q & enable_q);
      reg_rvalid <= rd_en;
      reg_rdata  <= rd_en ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_hosted_npu_irq_ctrl.sv
// tb_hosted_npu_irq_ctrl
// Directed test of hosted_npu_irq_ctrl with a cycle-level behavioural model
// compared against the DUT outputs every cycle, plus literal expectations.
module tb_hosted_npu_irq_ctrl;
  import hosted_npu_irq_ctrl_pkg::*;

  localparam int N_CH       = 4;
  localparam int RST_CYCLES = 16;
  localparam int ADDR_W     = 3;

  logic              clk = 1'b0;
  logic              srst = 1'b1;
  logic [N_CH-1:0]   irq_in = '0;
  logic [N_CH-1:0]   npu_rst_n;
  logic              irq_core;
  logic              reg_valid = 1'b0;
  logic              reg_write = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic [31:0]       reg_wdata = '0;
  logic              reg_ready;
  logic              reg_rvalid;
  logic [31:0]       reg_rdata;

  int vectors = 0;
  int miscompares = 0;

  hosted_npu_irq_ctrl #(
    .N_CH(N_CH), .RST_CYCLES(RST_CYCLES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .srst(srst), .irq_in(irq_in), .npu_rst_n(npu_rst_n),
    .irq_core(irq_core), .reg_valid(reg_valid), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ready(reg_ready),
    .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input int a,
                               input logic [31:0] d);
    reg_valid = v;
    reg_write = w;
    reg_addr  = ADDR_W'(a);
    reg_wdata = d;
  endtask

  task automatic writeReg(input int a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic readReg(input int a, input logic [31:0] expected, input string name);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 32'h0);
    @(negedge clk);
    checkOutput({name, "_rvalid"}, 32'(reg_rvalid), 32'h1);
    checkOutput(name, reg_rdata, expected);
    tick();
  endtask

  // Behavioural model: per-channel integers and bit arrays, advanced once per clock.
  int              busy_left [N_CH];
  bit [N_CH-1:0]   m_pend, m_en, m_mode, m_hist;
  bit              m_irq, m_rvalid;
  bit [31:0]       m_rdata;
  bit              model_on = 1'b0;

  always @(posedge clk) begin
    bit            is_rd, is_wr, forced;
    int            claim_id;
    bit [31:0]     rd;
    bit [N_CH-1:0] w1c, start, n_pend, n_hist;
    if (srst) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_hist = '1;
      m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      for (int i = 0; i < N_CH; i++) busy_left[i] = RST_CYCLES;
    end else begin
      is_rd = reg_valid && !reg_write;
      is_wr = reg_valid && reg_write;
      claim_id = -1;
      for (int i = N_CH - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) claim_id = i;
      rd = '0;
      case (int'(reg_addr))
        0: rd = 32'(m_pend);
        1: rd = 32'(m_en);
        2: rd = 32'(m_mode);
        3: for (int i = 0; i < N_CH; i++) rd[i] = (busy_left[i] > 0);
        4: if (claim_id >= 0) rd = 32'h8000_0000 + 32'(claim_id);
        default: rd = '0;
      endcase
      w1c   = (is_wr && reg_addr == 0) ? reg_wdata[N_CH-1:0] : '0;
      start = (is_wr && reg_addr == 3) ? reg_wdata[N_CH-1:0] : '0;
      for (int i = 0; i < N_CH; i++) begin
        forced = (busy_left[i] > 0) || start[i];
        if (forced) begin
          n_pend[i] = 1'b0;
          n_hist[i] = 1'b1;
        end else begin
          n_hist[i] = irq_in[i];
          if (!m_mode[i])                       n_pend[i] = irq_in[i];
          else if (irq_in[i] && !m_hist[i])     n_pend[i] = 1'b1;
          else if (w1c[i] || (is_rd && reg_addr == 4 && claim_id == i))
                                                n_pend[i] = 1'b0;
          else                                  n_pend[i] = m_pend[i];
        end
      end
      m_irq    = |(m_pend & m_en);
      m_rvalid = is_rd;
      m_rdata  = is_rd ? rd : '0;
      if (is_wr && reg_addr == 1) m_en   = reg_wdata[N_CH-1:0];
      if (is_wr && reg_addr == 2) m_mode = reg_wdata[N_CH-1:0];
      for (int i = 0; i < N_CH; i++) begin
        if (busy_left[i] > 0) busy_left[i]--;
        else if (start[i])    busy_left[i] = RST_CYCLES;
      end
      m_pend = n_pend;
      m_hist = n_hist;
    end
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    bit [N_CH-1:0] exp_rst_n;
    if (model_on) begin
      for (int i = 0; i < N_CH; i++) exp_rst_n[i] = (busy_left[i] == 0);
      checkOutput("model_npu_rst_n", 32'(npu_rst_n), 32'(exp_rst_n));
      checkOutput("model_irq_core", 32'(irq_core), 32'(m_irq));
      checkOutput("model_rvalid", 32'(reg_rvalid), 32'(m_rvalid));
      checkOutput("model_ready", 32'(reg_ready), 32'h1);
      if (m_rvalid) checkOutput("model_rdata", reg_rdata, m_rdata);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and release sequence
    tick();
    @(negedge clk);
    checkOutput("srst_irq_core", 32'(irq_core), 32'h0);
    checkOutput("srst_rvalid", 32'(reg_rvalid), 32'h0);
    checkOutput("srst_rdata", reg_rdata, 32'h0);
    checkOutput("srst_rst_n", 32'(npu_rst_n), 32'h0);
    tick();
    tick();
    srst = 1'b0;
    for (int c = 0; c < RST_CYCLES; c++) begin
      @(negedge clk);
      checkOutput($sformatf("release_low_c%0d", c), 32'(npu_rst_n), 32'h0);
      tick();
    end
    @(negedge clk);
    checkOutput("release_high", 32'(npu_rst_n), 32'hF);
    tick();
    for (int a = 0; a < 8; a++) readReg(a, 32'h0, $sformatf("reset_reg%0d", a));

    // Edge mode, single-cycle pulse on channel 2
    writeReg(IRQ_MODE, 32'hF);
    writeReg(IRQ_ENABLE, 32'h5);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    @(negedge clk);
    checkOutput("edge_irq_t1", 32'(irq_core), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("edge_irq_t2", 32'(irq_core), 32'h1);
    tick();
    readReg(IRQ_PENDING, 32'h4, "edge_pending");
    writeReg(IRQ_PENDING, 32'h4);
    @(negedge clk);
    checkOutput("w1c_irq_t1", 32'(irq_core), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("w1c_irq_t2", 32'(irq_core), 32'h0);
    tick();

    // Level mode on channel 1
    writeReg(IRQ_MODE, 32'h0);
    writeReg(IRQ_ENABLE, 32'h2);
    irq_in[1] = 1'b1;
    tick();
    tick();
    writeReg(IRQ_PENDING, 32'h2);
    readReg(IRQ_PENDING, 32'h2, "level_w1c_ignored");
    @(negedge clk);
    checkOutput("level_irq", 32'(irq_core), 32'h1);
    tick();
    irq_in[1] = 1'b0;
    tick();
    readReg(IRQ_PENDING, 32'h0, "level_drop");

    // Claim ordering with channels 1 and 3 pending
    writeReg(IRQ_MODE, 32'hF);
    writeReg(IRQ_ENABLE, 32'hF);
    irq_in = 4'b1010;
    tick();
    irq_in = '0;
    tick();
    readReg(IRQ_CLAIM, 32'h8000_0001, "claim_first");
    readReg(IRQ_CLAIM, 32'h8000_0003, "claim_second");
    readReg(IRQ_CLAIM, 32'h0000_0000, "claim_empty");

    // Reset pulse on channel 1 with an ignored restart and a masked edge
    writeReg(IRQ_RST_CTRL, 32'h2);
    for (int c = 1; c <= RST_CYCLES; c++) begin
      if (c == 5)      applyStimulus(1'b1, 1'b1, IRQ_RST_CTRL, 32'h2);
      else if (c == 7) applyStimulus(1'b1, 1'b0, IRQ_RST_CTRL, 32'h0);
      else             applyStimulus(1'b0, 1'b0, 0, 32'h0);
      irq_in[1] = (c == 9);
      @(negedge clk);
      checkOutput($sformatf("pulse_rst_n_c%0d", c), 32'(npu_rst_n), 32'hD);
      if (c == 8) checkOutput("pulse_busy_read", reg_rdata, 32'h2);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 0, 32'h0);
    irq_in = '0;
    @(negedge clk);
    checkOutput("pulse_end", 32'(npu_rst_n), 32'hF);
    tick();
    readReg(IRQ_PENDING, 32'h0, "pulse_irq_masked");

    // Edge set coinciding with W1C on channel 0
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b1, IRQ_PENDING, 32'h1);
    irq_in[0] = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 0, 32'h0);
    irq_in[0] = 1'b0;
    readReg(IRQ_PENDING, 32'h1, "set_beats_w1c");
    writeReg(IRQ_PENDING, 32'h1);
    readReg(IRQ_PENDING, 32'h0, "w1c_clears");

    // srst in the middle of a pulse restarts every channel
    writeReg(IRQ_RST_CTRL, 32'h1);
    repeat (5) tick();
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    repeat (RST_CYCLES + 3) tick();
    readReg(IRQ_ENABLE, 32'h0, "srst_enable");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
